// File: rtl/zero_cross_meter.sv
// Rising zero-crossing period meter with hysteresis, sample-valid gating,
// power-of-two period averaging and counter-saturation timeout.
module zero_cross_meter #(
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 10,
    parameter int HYST     = 1000,
    parameter int AVG_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     x_valid,
    output logic                     flag,
    output logic [CNT_W-1:0]         period,
    output logic                     period_valid,
    output logic [CNT_W-1:0]         avg,
    output logic                     avg_valid,
    output logic                     timeout
);

    localparam int                        ACC_W    = CNT_W + AVG_LOG2;
    localparam logic signed [DATA_W-1:0]  HYST_POS = $signed(DATA_W'(HYST));
    localparam logic signed [DATA_W-1:0]  HYST_NEG = -HYST_POS;
    localparam logic [CNT_W-1:0]          CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [AVG_LOG2-1:0]       GRP_LAST = '1;
    localparam logic [AVG_LOG2-1:0]       GRP_ONE  = AVG_LOG2'(1);

    typedef enum logic [1:0] {
        S_LOCK,
        S_NEG,
        S_POS
    } state_t;

    state_t              r_state;
    logic                r_firstSeen;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_grpCnt;
    logic [ACC_W-1:0]    r_avgSum;
    logic                r_avgPend;

    logic                w_below;
    logic                w_above;
    logic                w_cross;
    logic [CNT_W-1:0]    w_periodNow;
    logic [ACC_W-1:0]    w_accSum;

    assign w_below     = (x < HYST_NEG);
    assign w_above     = (x >= HYST_POS);
    assign w_cross     = x_valid && (r_state == S_NEG) && w_above;
    assign w_periodNow = r_cnt + CNT_ONE;
    assign w_accSum    = r_acc + ACC_W'(w_periodNow);

    // The completed group sum is parked in r_avgSum so avg lands one cycle
    // after the period_valid that closed the group.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_LOCK;
            r_firstSeen  <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_grpCnt     <= '0;
            r_avgSum     <= '0;
            r_avgPend    <= 1'b0;
            flag         <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            avg          <= '0;
            avg_valid    <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            flag         <= 1'b0;
            period_valid <= 1'b0;
            avg_valid    <= 1'b0;

            if (r_avgPend) begin
                avg       <= CNT_W'(r_avgSum >> AVG_LOG2);
                avg_valid <= 1'b1;
                r_avgPend <= 1'b0;
            end

            if (x_valid) begin
                case (r_state)
                    S_LOCK:  if (w_below) r_state <= S_NEG;
                    S_NEG:   if (w_above) r_state <= S_POS;
                    S_POS:   if (w_below) r_state <= S_NEG;
                    default: r_state <= S_LOCK;
                endcase

                if (w_cross) begin
                    flag  <= 1'b1;
                    r_cnt <= '0;
                    if (!r_firstSeen) begin
                        r_firstSeen <= 1'b1;
                    end else if (timeout) begin
                        // A saturated interval is meaningless; drop it and the group.
                        timeout  <= 1'b0;
                        r_acc    <= '0;
                        r_grpCnt <= '0;
                    end else begin
                        period       <= w_periodNow;
                        period_valid <= 1'b1;
                        if (r_grpCnt == GRP_LAST) begin
                            r_avgSum  <= w_accSum;
                            r_avgPend <= 1'b1;
                            r_acc     <= '0;
                            r_grpCnt  <= '0;
                        end else begin
                            r_acc    <= w_accSum;
                            r_grpCnt <= r_grpCnt + GRP_ONE;
                        end
                    end
                end else if (r_firstSeen) begin
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    if (r_cnt >= (CNT_MAX - CNT_ONE)) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_zero_cross_meter.sv
// Directed self-checking bench for zero_cross_meter at default parameters.
module tb_zero_cross_meter;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] x;
    logic               x_valid;
    logic               flag;
    logic [9:0]         period;
    logic               period_valid;
    logic [9:0]         avg;
    logic               avg_valid;
    logic               timeout;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    int flagCount;
    int pvCount;
    int avCount;
    int flagCycle[16];
    int pvCycle[16];
    int pvVal[16];
    int avCycle[16];
    int avVal[16];
    int timeoutRise;

    zero_cross_meter #(
        .DATA_W   (32),
        .CNT_W    (10),
        .HYST     (1000),
        .AVG_LOG2 (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .x_valid      (x_valid),
        .flag         (flag),
        .period       (period),
        .period_valid (period_valid),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        flagCount = 0;
        pvCount   = 0;
        avCount   = 0;
        for (int i = 0; i < 16; i++) begin
            flagCycle[i] = 0;
            pvCycle[i]   = 0;
            pvVal[i]     = 0;
            avCycle[i]   = 0;
            avVal[i]     = 0;
        end
    endtask

    // One clock per call; outputs are logged 1 time unit after the edge.
    task automatic applyStimulus(input int xv, input logic v);
        x       = xv;
        x_valid = v;
        @(posedge clk);
        #1;
        cycle++;
        if (flag) begin
            if (flagCount < 16) flagCycle[flagCount] = cycle;
            flagCount++;
        end
        if (period_valid) begin
            if (pvCount < 16) begin
                pvCycle[pvCount] = cycle;
                pvVal[pvCount]   = int'(period);
            end
            pvCount++;
        end
        if (avg_valid) begin
            if (avCount < 16) begin
                avCycle[avCount] = cycle;
                avVal[avCount]   = int'(avg);
            end
            avCount++;
        end
    endtask

    task automatic doReset();
        reset   = 1'b1;
        x       = 0;
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        cycle++;
        reset = 1'b0;
        clearLog();
    endtask

    task automatic sendBlock(input int negLen, input int posLen, input logic gap);
        for (int i = 0; i < negLen; i++) begin
            applyStimulus(-5000, 1'b1);
            if (gap) applyStimulus(-5000, 1'b0);
        end
        for (int i = 0; i < posLen; i++) begin
            applyStimulus(5000, 1'b1);
            if (gap) applyStimulus(5000, 1'b0);
        end
    endtask

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "_flag"},    int'(flag),         0);
        checkOutput({pfx, "_period"},  int'(period),       0);
        checkOutput({pfx, "_pvalid"},  int'(period_valid), 0);
        checkOutput({pfx, "_avg"},     int'(avg),          0);
        checkOutput({pfx, "_avalid"},  int'(avg_valid),    0);
        checkOutput({pfx, "_timeout"}, int'(timeout),      0);
    endtask

    initial begin
        reset   = 1'b0;
        x       = 0;
        x_valid = 1'b0;

        doReset();
        checkAllZero("rst");

        // Square wave, 4 low / 4 high, crossing every 8 samples.
        for (int b = 0; b < 6; b++) sendBlock(4, 4, 1'b0);
        checkOutput("sq_flags",     flagCount, 6);
        checkOutput("sq_pvcount",   pvCount, 5);
        checkOutput("sq_firstnopv", pvCycle[0], flagCycle[1]);
        checkOutput("sq_flagspace", flagCycle[5] - flagCycle[4], 8);
        checkOutput("sq_period0",   pvVal[0], 8);
        checkOutput("sq_period4",   pvVal[4], 8);
        checkOutput("sq_avcount",   avCount, 1);
        checkOutput("sq_avg",       avVal[0], 8);
        checkOutput("sq_avlatency", avCycle[0], pvCycle[3] + 1);
        checkOutput("sq_periodhold", int'(period), 8);

        // Noise inside the hysteresis band must not trigger anything.
        doReset();
        applyStimulus(-5000, 1'b1);
        for (int i = 0; i < 200; i++) applyStimulus((i % 2 == 0) ? 900 : -900, 1'b1);
        checkOutput("nz_flags",   flagCount, 0);
        checkOutput("nz_pvcount", pvCount, 0);
        applyStimulus(5000, 1'b1);
        checkOutput("nz_firstflag", flagCount, 1);
        checkOutput("nz_firstnopv", pvCount, 0);
        for (int i = 0; i < 4; i++) applyStimulus(-5000, 1'b1);
        applyStimulus(5000, 1'b1);
        checkOutput("nz_period5", int'(period), 5);

        // Periods 8, 10, 12, 11 average to 41 >> 2 = 10.
        doReset();
        sendBlock(4, 4, 1'b0);
        sendBlock(4, 5, 1'b0);
        sendBlock(5, 6, 1'b0);
        sendBlock(6, 6, 1'b0);
        sendBlock(5, 4, 1'b0);
        checkOutput("av_pvcount", pvCount, 4);
        checkOutput("av_p0", pvVal[0], 8);
        checkOutput("av_p1", pvVal[1], 10);
        checkOutput("av_p2", pvVal[2], 12);
        checkOutput("av_p3", pvVal[3], 11);
        checkOutput("av_count",   avCount, 1);
        checkOutput("av_value",   avVal[0], 10);
        checkOutput("av_latency", avCycle[0], pvCycle[3] + 1);
        checkOutput("av_hold",    int'(avg), 10);

        // Timeout: 1023 samples after a crossing saturate the counter.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(-5000, 1'b1);
        applyStimulus(5000, 1'b1);
        checkOutput("to_firstflag", int'(flag), 1);
        timeoutRise = -1;
        for (int i = 1; i <= 1100; i++) begin
            applyStimulus(5000, 1'b1);
            if (timeout && timeoutRise < 0) timeoutRise = i;
        end
        checkOutput("to_rise", timeoutRise, 1023);
        applyStimulus(-5000, 1'b1);
        checkOutput("to_held", int'(timeout), 1);
        applyStimulus(5000, 1'b1);
        checkOutput("to_xflag",  int'(flag), 1);
        checkOutput("to_xnopv",  int'(period_valid), 0);
        checkOutput("to_clear",  int'(timeout), 0);
        for (int i = 0; i < 3; i++) applyStimulus(5000, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(-5000, 1'b1);
        applyStimulus(5000, 1'b1);
        checkOutput("to_after_pv",     int'(period_valid), 1);
        checkOutput("to_after_period", int'(period), 8);
        checkOutput("to_pvcount",      pvCount, 1);

        // Crossing on the sample that would saturate still publishes 1023.
        for (int i = 0; i < 1021; i++) applyStimulus(5000, 1'b1);
        applyStimulus(-5000, 1'b1);
        checkOutput("sat_pre_timeout", int'(timeout), 0);
        applyStimulus(5000, 1'b1);
        checkOutput("sat_pv",      int'(period_valid), 1);
        checkOutput("sat_period",  int'(period), 1023);
        checkOutput("sat_timeout", int'(timeout), 0);

        // Strobe every other cycle: period in samples, spacing in clocks.
        doReset();
        for (int b = 0; b < 6; b++) sendBlock(4, 4, 1'b1);
        checkOutput("gap_flags",     flagCount, 6);
        checkOutput("gap_flagspace", flagCycle[5] - flagCycle[4], 16);
        checkOutput("gap_pvcount",   pvCount, 5);
        checkOutput("gap_period",    pvVal[4], 8);

        // Reset midway through the third period discards everything.
        doReset();
        sendBlock(4, 4, 1'b0);
        sendBlock(4, 4, 1'b0);
        sendBlock(4, 4, 1'b0);
        applyStimulus(5000, 1'b1);
        applyStimulus(-5000, 1'b1);
        checkOutput("mid_pvcount", pvCount, 2);
        doReset();
        checkAllZero("mid_rst");
        for (int b = 0; b < 5; b++) sendBlock(4, 4, 1'b0);
        checkOutput("mid_flags",     flagCount, 5);
        checkOutput("mid_firstnopv", pvCycle[0], flagCycle[1]);
        checkOutput("mid_period",    pvVal[0], 8);
        checkOutput("mid_avcount",   avCount, 1);
        checkOutput("mid_avlatency", avCycle[0], pvCycle[3] + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
